// File: rtl/avalon_regbank_if.sv
// Avalon-MM slave bus bundle for avalon_regbank: host-driven strobes,
// address and write data, plus the registered read data, read-valid and irq.
interface avalon_regbank_if #(
  parameter int DATA_W = 32,
  parameter int N_REGS = 8
);
  localparam int ADDR_W = $clog2(N_REGS);

  // No waitrequest: every cycle is an access slot. A write is taken when
  // iChipselect=1 and iWrite_n=0. A read is taken when iChipselect=1,
  // iRead_n=0 and iWrite_n=1. oReadDataValid pulses for exactly one cycle,
  // one cycle after each taken read.
  logic                  iChipselect;
  logic                  iWrite_n;
  logic                  iRead_n;
  logic [ADDR_W-1:0]     iAddress;
  logic [DATA_W/8-1:0]   iByteEnable;
  logic [DATA_W-1:0]     iData;
  logic [DATA_W-1:0]     oData;
  logic                  oReadDataValid;
  logic                  oIrq;

  modport master (
    output iChipselect, iWrite_n, iRead_n, iAddress, iByteEnable, iData,
    input  oData, oReadDataValid, oIrq
  );

  modport slave (
    input  iChipselect, iWrite_n, iRead_n, iAddress, iByteEnable, iData,
    output oData, oReadDataValid, oIrq
  );
endinterface

// File: rtl/avalon_regbank.sv
// Avalon-MM register bank: CTRL at word 0, general RW words, DOORBELL at the top word.
// Byte-lane write masking is enabled by defining AVL_REGBANK_BYTEEN_EN.
module avalon_regbank #(
  parameter  int DATA_W = 32,
  parameter  int N_REGS = 8,
  localparam int ADDR_W = $clog2(N_REGS)
) (
  input logic               iClk,
  input logic               iReset,
  avalon_regbank_if.slave   bus
);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = '0;
  localparam logic [ADDR_W-1:0] DB_ADDR   = ADDR_W'(N_REGS - 1);

  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] ctrl_word;

  logic [DATA_W-1:0] words_q [N_REGS];
  logic [DATA_W-1:0] words_d [N_REGS];
  logic              irq_en_q, irq_en_d;
  logic              pending_q, pending_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  assign wr_acc = bus.iChipselect & ~bus.iWrite_n;
  assign rd_acc = bus.iChipselect & ~bus.iRead_n & bus.iWrite_n;

`ifdef AVL_REGBANK_BYTEEN_EN
  always_comb begin
    wmask = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      wmask[8*b +: 8] = {8{bus.iByteEnable[b]}};
    end
  end
`else
  logic unused_byteen;
  assign unused_byteen = ^bus.iByteEnable;
  assign wmask = '1;
`endif

  always_comb begin
    ctrl_word       = '0;
    ctrl_word[0]    = irq_en_q;
    ctrl_word[1]    = pending_q;
    ctrl_word[15:8] = wcnt_q;
  end

  // Word 0 of words_q is never written; CTRL lives in the dedicated fields.
  always_comb begin
    words_d   = words_q;
    irq_en_d  = irq_en_q;
    pending_d = pending_q;
    wcnt_d    = wcnt_q;
    rdata_d   = rdata_q;
    rvalid_d  = rd_acc;
    if (wr_acc) begin
      if (bus.iAddress == CTRL_ADDR) begin
        irq_en_d = bus.iData[0];
        if (bus.iData[1]) begin
          pending_d = 1'b0;
        end
      end else begin
        words_d[bus.iAddress] = (words_q[bus.iAddress] & ~wmask) | (bus.iData & wmask);
        if (bus.iAddress == DB_ADDR) begin
          pending_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
    end
    if (rd_acc) begin
      rdata_d = (bus.iAddress == CTRL_ADDR) ? ctrl_word : words_q[bus.iAddress];
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      for (int i = 0; i < N_REGS; i++) begin
        words_q[i] <= '0;
      end
      irq_en_q  <= 1'b0;
      pending_q <= 1'b0;
      wcnt_q    <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      words_q   <= words_d;
      irq_en_q  <= irq_en_d;
      pending_q <= pending_d;
      wcnt_q    <= wcnt_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign bus.oData          = rdata_q;
  assign bus.oReadDataValid = rvalid_q;
  assign bus.oIrq           = irq_en_q & pending_q;
endmodule

// File: tb/tb_avalon_regbank.sv
// Directed bench for avalon_regbank (DATA_W=32, N_REGS=8); read data is
// scoreboarded through exp_q by a negedge monitor.
module tb_avalon_regbank;
  localparam int DATA_W = 32;
  localparam int N_REGS = 8;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   pulses   = 0;
  int   p0;
  logic [DATA_W-1:0] exp_q[$];

  avalon_regbank_if #(.DATA_W(DATA_W), .N_REGS(N_REGS)) bus ();

  avalon_regbank #(.DATA_W(DATA_W), .N_REGS(N_REGS)) dut (
    .iClk   (clk),
    .iReset (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.iChipselect = 1'b0;
    bus.iWrite_n    = 1'b1;
    bus.iRead_n     = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.iChipselect = 1'b1;
    bus.iWrite_n    = 1'b0;
    bus.iRead_n     = 1'b1;
    bus.iAddress    = a;
    bus.iData       = d;
    bus.iByteEnable = be;
    @(posedge clk);
  endtask

  // Read with latency check; data is compared by the monitor.
  task automatic rd(input logic [2:0] a, input logic [31:0] e);
    @(negedge clk);
    bus.iChipselect = 1'b1;
    bus.iWrite_n    = 1'b1;
    bus.iRead_n     = 1'b0;
    bus.iAddress    = a;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check("rd_latency", bus.oReadDataValid, 1);
  endtask

  always @(negedge clk) begin
    if (bus.oReadDataValid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("spurious_rvalid", 1, 0);
      end else begin
        check("rdata", bus.oData, exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.iChipselect = 1'b0;
    bus.iWrite_n    = 1'b1;
    bus.iRead_n     = 1'b1;
    bus.iAddress    = '0;
    bus.iData       = '0;
    bus.iByteEnable = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_odata", bus.oData, 0);
    check("rst_rvalid", bus.oReadDataValid, 0);
    check("rst_irq", bus.oIrq, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < N_REGS; i++) rd(3'(i), 32'h0);
    idle();
    idle();
    check("rst_read_pulses", pulses, 8);
    check("idle_rvalid", bus.oReadDataValid, 0);

    wr(3'd1, 32'hDEADBEEF, 4'hF);
    rd(3'd1, 32'hDEADBEEF);
    rd(3'd0, 32'h0000_0100);

    wr(3'd2, 32'h11223344, 4'hF);
    wr(3'd2, 32'hAABBCCDD, 4'b0101);
`ifdef AVL_REGBANK_BYTEEN_EN
    rd(3'd2, 32'h11BB33DD);
`else
    rd(3'd2, 32'hAABBCCDD);
`endif

    wr(3'd0, 32'h1, 4'hF);
    #1 check("irq_en_only", bus.oIrq, 0);
    rd(3'd0, 32'h0000_0301);
    wr(3'd7, 32'h5, 4'hF);
    #1 check("irq_rise", bus.oIrq, 1);
    rd(3'd7, 32'h5);
    rd(3'd0, 32'h0000_0303);
    wr(3'd0, 32'h3, 4'hF);
    #1 check("irq_fall_w1c", bus.oIrq, 0);
    rd(3'd0, 32'h0000_0301);

    wr(3'd0, 32'h0, 4'hF);
    wr(3'd7, 32'h7, 4'hF);
    #1 check("irq_masked", bus.oIrq, 0);
    rd(3'd0, 32'h0000_0302);
    wr(3'd0, 32'h2, 4'hF);
    wr(3'd0, 32'h2, 4'hF);
    rd(3'd0, 32'h0000_0300);

    // WCNT is 3 here, so 253 more general writes land exactly on the wrap.
    for (int i = 0; i < 253; i++) wr(3'd3, 32'(i), 4'hF);
    rd(3'd0, 32'h0000_0000);
    rd(3'd3, 32'd252);

    idle();
    idle();
    p0 = pulses;
    @(negedge clk);
    bus.iChipselect = 1'b1;
    bus.iWrite_n    = 1'b0;
    bus.iRead_n     = 1'b0;
    bus.iAddress    = 3'd3;
    bus.iData       = 32'h12345678;
    bus.iByteEnable = 4'hF;
    idle();
    idle();
    check("rw_no_pulse", pulses, p0);
    rd(3'd3, 32'h12345678);
    rd(3'd0, 32'h0000_0100);

    idle();
    idle();
    p0 = pulses;
    @(negedge clk);
    bus.iChipselect = 1'b0;
    bus.iWrite_n    = 1'b0;
    bus.iRead_n     = 1'b0;
    bus.iAddress    = 3'd3;
    bus.iData       = 32'hFFFFFFFF;
    @(negedge clk);
    bus.iAddress    = 3'd0;
    bus.iData       = 32'h3;
    idle();
    idle();
    check("cs_low_no_pulse", pulses, p0);
    rd(3'd3, 32'h12345678);
    rd(3'd0, 32'h0000_0100);

    rd(3'd3, 32'h12345678);
    @(negedge clk);
    bus.iChipselect = 1'b0;
    bus.iRead_n     = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_after_rd_rvalid", bus.oReadDataValid, 0);
    check("rst_after_rd_odata", bus.oData, 0);
    @(negedge clk);
    bus.iChipselect = 1'b1;
    bus.iRead_n     = 1'b0;
    bus.iAddress    = 3'd1;
    @(posedge clk);
    #1;
    check("rst_same_cycle_rvalid", bus.oReadDataValid, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.iChipselect = 1'b0;
    bus.iRead_n     = 1'b1;
    rd(3'd3, 32'h0);
    rd(3'd1, 32'h0);
    rd(3'd0, 32'h0);
    rd(3'd7, 32'h0);

    idle();
    idle();
    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/avalon_regbank.md
# avalon_regbank

Parametrised Avalon-MM slave register bank: next generation of the team's four-word Avalon test slave. Generalised to N words of DATA_W bits with byte-lane writes, a registered read port with an explicit read-valid strobe, a control/status word, and a doorbell register that raises an interrupt to the host CPU. Sits on the system Avalon interconnect as a peripheral scratch/mailbox block.

## Interface
- DATA_W, 32, data width in bits; multiple of 8, 16..64
- N_REGS, 8, number of words; power of two, 4..256
- ADDR_W, $clog2(N_REGS), word address width (derived; do not override)
- iClk  in  1  clock; all logic on rising edge
- iReset  in  1  synchronous, active-high reset
- iChipselect  in  1  slave select; all accesses ignored when low
- iWrite_n  in  1  active-low write strobe
- iRead_n  in  1  active-low read strobe
- iAddress  in  ADDR_W  word address
- iByteEnable  in  DATA_W/8  per-byte write enable (see Configuration)
- iData  in  DATA_W  write data
- oData  out  DATA_W  read data, registered
- oReadDataValid  out  1  one-cycle pulse marking oData valid
- oIrq  out  1  level interrupt to host

## Operation
- Address map: 0 = CTRL; 1..N_REGS-2 = general RW words; N_REGS-1 = DOORBELL.
- CTRL: bit0 IRQ_EN (RW); bit1 PENDING (read; write 1 clears, write 0 no effect); bits[15:8] WCNT (RO), count of accepted writes to general words, 8-bit wrap 0xFF->0x00; all other bits read 0, writes ignored.
- General words: write updates only byte lanes whose iByteEnable bit is 1.
- DOORBELL: write stores data (byte-lane masked) and sets PENDING regardless of data value; reads return stored value.
- Write accepted when iChipselect=1 and iWrite_n=0. Read accepted when iChipselect=1, iRead_n=0 and iWrite_n=1.
- Read and write asserted together: write performed, read ignored, no oReadDataValid.
- oIrq = IRQ_EN & PENDING, driven from registers (no combinational path from inputs).
- oData holds last read value until the next accepted read.
- Write to CTRL with bit1=1 when PENDING=0: no effect. Doorbell write always sets PENDING (no conflict possible: one access per cycle).
- Writes to CTRL and DOORBELL do not increment WCNT.

## Timing
- Reset (iReset=1 at clock edge): all words 0, IRQ_EN=0, PENDING=0, WCNT=0, oData=0, oReadDataValid=0, oIrq=0. Reset overrides any access in the same cycle; a read accepted the cycle before reset produces no valid pulse after reset.
- Write: register updated at the accepting edge; visible to a read accepted on the next cycle.
- Read: fixed latency 1; oData and oReadDataValid=1 on the edge after acceptance; oReadDataValid=0 otherwise. Back-to-back reads give back-to-back valid pulses.
- Read of a word written in the same cycle: not possible (write wins, see above).
- oIrq rises the cycle after the accepting DOORBELL write (if IRQ_EN=1); falls the cycle after the W1C write or IRQ_EN clear.
- No waitrequest; slave accepts every cycle.

## Configuration
- AVL_REGBANK_BYTEEN_EN defined: iByteEnable masks writes as above for general and DOORBELL words (CTRL always uses full word).
- Undefined: iByteEnable port still present but ignored; every write updates all DATA_W bits.

## Test plan
- Reset then read each address 0..N_REGS-1 -> every oData=0, one oReadDataValid pulse per read, one cycle after request.
- Write 0xDEADBEEF to addr 1, then read addr 1 next cycle -> oData=0xDEADBEEF at latency 1; CTRL WCNT=1.
- (BYTEEN_EN) Addr 2 holds 0x11223344; write 0xAABBCCDD with iByteEnable=4'b0101 -> read 0x11BB33DD; without macro -> 0xAABBCCDD.
- Write CTRL=0x1, write DOORBELL=0x5 -> oIrq=1 next cycle; write CTRL=0x3 -> PENDING and oIrq=0 next cycle, IRQ_EN stays 1.
- 256 writes to addr 3 -> WCNT wraps to 0x00; simultaneous iRead_n=0/iWrite_n=0 on addr 3 -> write performed, no valid pulse.
- Read accepted, iReset=1 next edge -> oReadDataValid stays 0, oData=0; iChipselect=0 with strobes active -> no state change, no pulse.
